// File: rtl/arb8way16_pkg.sv
// Shared types and constants for the 8-way round-robin arbiter.
// Holds the FSM state encoding and the pointer advance rule.
package arb_pkg;

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   localparam int N_REQ = 8;
   localparam int SEL_W = 3;

   // N_REQ is a power of two, so the 3-bit add wraps 7 -> 0 by itself
   function automatic logic [SEL_W-1:0] rr_next(input logic [SEL_W-1:0] ptr);
      return ptr + SEL_W'(1);
   endfunction

endpackage

// File: rtl/arb8way16_rr_pick8.sv
// Rotating-priority picker: first set request at or above ptr, wrapping 7 -> 0.
// Rotates a doubled request vector down by ptr, then priority-encodes the result.
module rr_pick8
   import arb_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [SEL_W-1:0] ptr,
   output logic [SEL_W-1:0] pick,
   output logic             any
);

   logic [2*N_REQ-1:0] w_dbl;
   logic [N_REQ-1:0]   w_rot;
   logic [SEL_W-1:0]   w_ofs;

   assign w_dbl = {req, req} >> ptr;
   assign w_rot = w_dbl[N_REQ-1:0];

   // Downward scan so the lowest set bit (closest to ptr) wins
   always_comb begin
      w_ofs = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (w_rot[i]) begin
            w_ofs = SEL_W'(i);
         end
      end
   end

   assign pick = ptr + w_ofs;
   assign any  = |req;

endmodule

// File: rtl/arb8way16.sv
// Round-robin arbiter and sequencer sharing one registered WIDTH-bit bus among eight requesters.
// Bursts end on done, on a dropped request or after MAX_HOLD beats; each release costs one idle cycle.
module arb8way16
   import arb_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter int MAX_HOLD = 15
)(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ-1:0]       done,
   input  logic [N_REQ*WIDTH-1:0] din,
   output logic [N_REQ-1:0]       grant,
   output logic [SEL_W-1:0]       sel,
   output logic [WIDTH-1:0]       dout,
   output logic                   dout_valid
);

   localparam int              CNT_W = 8;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(MAX_HOLD - 1);

   state_t              r_state;
   logic [N_REQ-1:0]    r_grant;
   logic [SEL_W-1:0]    r_sel;
   logic [SEL_W-1:0]    r_ptr;
   logic [CNT_W-1:0]    r_cnt;
   logic [WIDTH-1:0]    r_dout;
   logic                r_valid;

   state_t              w_state_nxt;
   logic [N_REQ-1:0]    w_grant_nxt;
   logic [SEL_W-1:0]    w_sel_nxt;
   logic [SEL_W-1:0]    w_ptr_nxt;
   logic [CNT_W-1:0]    w_cnt_nxt;
   logic [WIDTH-1:0]    w_dout_nxt;
   logic                w_valid_nxt;

   logic [SEL_W-1:0]    w_pick;
   logic                w_any;
   logic [WIDTH-1:0]    w_words [N_REQ];
   logic [WIDTH-1:0]    w_mux;
   logic                w_req_g;
   logic                w_done_g;

   rr_pick8 u_pick (
      .req  (req),
      .ptr  (r_ptr),
      .pick (w_pick),
      .any  (w_any)
   );

   // 8-way data multiplexer, steered by the registered select code
   for (genvar k = 0; k < N_REQ; k++) begin : g_words
      assign w_words[k] = din[k*WIDTH +: WIDTH];
   end

   assign w_mux    = w_words[r_sel];
   assign w_req_g  = req[r_sel];
   assign w_done_g = done[r_sel];

   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant;
      w_sel_nxt   = r_sel;
      w_ptr_nxt   = r_ptr;
      w_cnt_nxt   = r_cnt;
      w_dout_nxt  = r_dout;
      w_valid_nxt = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_any) begin
               w_grant_nxt = N_REQ'(1) << w_pick;
               w_sel_nxt   = w_pick;
               w_cnt_nxt   = '0;
               w_state_nxt = BUSY;
            end
         end
         BUSY: begin
            if (w_req_g) begin
               w_dout_nxt  = w_mux;
               w_valid_nxt = 1'b1;
               w_cnt_nxt   = r_cnt + CNT_W'(1);
            end
            // done, dropped request and timeout all collapse into one release
            if (!w_req_g || w_done_g || (r_cnt == LAST)) begin
               w_grant_nxt = '0;
               w_ptr_nxt   = rr_next(r_sel);
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_grant_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_grant <= '0;
         r_sel   <= '0;
         r_ptr   <= '0;
         r_cnt   <= '0;
         r_dout  <= '0;
         r_valid <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_grant <= w_grant_nxt;
         r_sel   <= w_sel_nxt;
         r_ptr   <= w_ptr_nxt;
         r_cnt   <= w_cnt_nxt;
         r_dout  <= w_dout_nxt;
         r_valid <= w_valid_nxt;
      end
   end

   assign grant      = r_grant;
   assign sel        = r_sel;
   assign dout       = r_dout;
   assign dout_valid = r_valid;

endmodule

// File: tb/tb_arb8way16.sv
// Randomised and directed bench for arb8way16 against a burst-level reference model.
module tb_arb8way16;

   localparam int W  = 16;
   localparam int MH = 4;

   logic           clk   = 1'b0;
   logic           rst_n = 1'b0;
   logic [7:0]     req   = '0;
   logic [7:0]     done  = '0;
   logic [8*W-1:0] din   = '0;
   logic [7:0]     grant;
   logic [2:0]     sel;
   logic [W-1:0]   dout;
   logic           dout_valid;

   int n_checks = 0;
   int n_errors = 0;
   bit hold_din = 1'b0;

   // reference model state
   bit         m_busy;
   int         m_g;
   int         m_beats;
   int         m_ptr;
   logic [7:0] m_grant;
   logic [2:0] m_sel;
   logic [W-1:0] m_dout;
   logic       m_valid;

   arb8way16 #(.WIDTH(W), .MAX_HOLD(MH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req),
      .done       (done),
      .din        (din),
      .grant      (grant),
      .sel        (sel),
      .dout       (dout),
      .dout_valid (dout_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed=%0h required=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_busy  = 1'b0;
      m_g     = 0;
      m_beats = 0;
      m_ptr   = 0;
      m_grant = '0;
      m_sel   = '0;
      m_dout  = '0;
      m_valid = 1'b0;
   endtask

   task automatic model_release();
      m_grant = '0;
      m_ptr   = (m_g + 1) % 8;
      m_busy  = 1'b0;
   endtask

   // one clock edge of the arbiter's behaviour, using the inputs it just sampled
   task automatic model_step();
      if (!m_busy) begin
         m_valid = 1'b0;
         if (req != 8'h00) begin
            int pick;
            pick = -1;
            for (int i = 0; i < 8; i++) begin
               int k;
               k = (m_ptr + i) % 8;
               if (pick < 0 && req[k]) pick = k;
            end
            m_g     = pick;
            m_sel   = 3'(pick);
            m_grant = 8'(1) << pick;
            m_beats = 0;
            m_busy  = 1'b1;
         end
      end else if (req[m_g]) begin
         m_dout  = din[m_g*W +: W];
         m_valid = 1'b1;
         m_beats++;
         if (done[m_g] || m_beats == MH) model_release();
      end else begin
         m_valid = 1'b0;
         model_release();
      end
   endtask

   task automatic compare();
      chk("grant", grant, m_grant);
      chk("sel", sel, m_sel);
      chk("dout_valid", dout_valid, m_valid);
      chk("dout", dout, m_dout);
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
      compare();
      din = {$urandom, $urandom, $urandom, $urandom};
      if (hold_din) din[2*W +: W] = 16'hBEEF;
   endtask

   task automatic idle(input int n);
      req  = '0;
      done = '0;
      for (int i = 0; i < n; i++) cyc();
   endtask

   initial begin
      int beats;
      model_reset();
      #1;
      chk("rst_grant", grant, 8'h00);
      chk("rst_sel", sel, 3'd0);
      chk("rst_dout", dout, 16'h0000);
      chk("rst_valid", dout_valid, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // timeout: two requesters alternate, MH beats each
      req = 8'h81;
      cyc();
      chk("to_grant0", grant, 8'h01);
      for (int i = 0; i < 5; i++) cyc();
      chk("to_grant7", grant, 8'h80);
      for (int i = 0; i < 5; i++) cyc();
      chk("to_back0", grant, 8'h01);
      idle(2);

      // single requester, done on the third beat
      hold_din = 1'b1;
      din[2*W +: W] = 16'hBEEF;
      req = 8'h04;
      cyc();
      chk("beef_grant", grant, 8'h04);
      beats = 0;
      cyc(); if (dout_valid && dout == 16'hBEEF) beats++;
      cyc(); if (dout_valid && dout == 16'hBEEF) beats++;
      done = 8'h04;
      cyc(); if (dout_valid && dout == 16'hBEEF) beats++;
      chk("beef_release", grant, 8'h00);
      req = 8'h00; done = 8'h00;
      cyc(); if (dout_valid && dout == 16'hBEEF) beats++;
      chk("beef_beats", beats, 3);
      hold_din = 1'b0;
      req = 8'h0C;
      cyc();
      chk("beef_ptr3", grant, 8'h08);
      idle(2);

      // fairness: everyone requesting, one-beat bursts
      req = 8'hFF; done = 8'hFF;
      for (int i = 0; i < 18; i++) cyc();
      idle(2);

      // request drop mid-burst
      req = 8'h20;
      cyc();
      chk("drop_grant5", grant, 8'h20);
      cyc();
      req = 8'h51;
      cyc();
      chk("drop_valid", dout_valid, 1'b0);
      chk("drop_release", grant, 8'h00);
      cyc();
      chk("drop_next6", grant, 8'h40);
      idle(2);

      // wrap-around from ptr 7
      req = 8'h40; done = 8'h40;
      cyc();
      cyc();
      req = 8'h03; done = 8'h00;
      cyc();
      chk("wrap_grant0", grant, 8'h01);
      idle(2);

      // async reset in the middle of a burst
      req = 8'h02;
      cyc();
      cyc();
      #2 rst_n = 1'b0;
      #1;
      chk("arst_grant", grant, 8'h00);
      chk("arst_dout", dout, 16'h0000);
      chk("arst_valid", dout_valid, 1'b0);
      chk("arst_sel", sel, 3'd0);
      model_reset();
      req = 8'h10;
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      cyc();
      chk("arst_grant4", grant, 8'h10);
      idle(2);

      // random traffic
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 3) != 0) req = 8'($urandom) & 8'($urandom);
         done = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
         cyc();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
